mux_arb_2_x_1: RTL

MUX_ARB_2_X_1 -- requirements
Module: mux_arb_2_x_1

---
 rtl/mux_arb_pkg.sv | 22 ++
 rtl/mux_2_x_1.sv | 11 +
 rtl/mux_arb_2_x_1.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester burst arbiter.
// State encoding is fixed so that gnt_a/gnt_b map onto individual state bits.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } arb_state_e;

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_e;

  localparam int CNT_W = 8;

  function automatic arb_state_e own_state(input side_e side);
    return (side == SIDE_A) ? OWN_A : OWN_B;
  endfunction

endpackage

// File: rtl/mux_2_x_1.sv
// Single-bit 2:1 multiplexer; control=1 selects a, control=0 selects b.
module mux_2_x_1 (
  input  logic control,
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = control ? a : b;

endmodule

// File: rtl/mux_arb_2_x_1.sv
// Two-requester burst arbiter with a shared output channel.
// Ownership is held for a whole burst and capped at MAX_BEATS accepted beats.
module mux_arb_2_x_1
  import mux_arb_pkg::*;
#(
  parameter int DATA_W    = 1,
  parameter int MAX_BEATS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  input  logic              last_a,
  input  logic              last_b,
  output logic              ready_a,
  output logic              ready_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  side_e            last_q, last_d;

  logic  sel;
  logic  accept;
  logic  own_req;
  logic  other_req;
  logic  burst_end;
  side_e own_side;
  side_e other_side;

  assign gnt_a     = (state_q == OWN_A);
  assign gnt_b     = (state_q == OWN_B);
  assign busy      = (state_q != IDLE);
  assign sel       = gnt_a;
  assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);
  assign ready_a   = gnt_a & req_a & out_ready;
  assign ready_b   = gnt_b & req_b & out_ready;
  assign accept    = out_valid & out_ready;

  assign own_side   = gnt_a ? SIDE_A : SIDE_B;
  assign other_side = gnt_a ? SIDE_B : SIDE_A;
  assign own_req    = gnt_a ? req_a : req_b;
  assign other_req  = gnt_a ? req_b : req_a;
  assign cnt_inc    = cnt_q + 1'b1;
  assign burst_end  = out_last || (cnt_inc == CNT_W'(MAX_BEATS));

  genvar i;
  generate
    for (i = 0; i < DATA_W; i++) begin : g_data_mux
      mux_2_x_1 u_data_mux (
        .control (sel),
        .a       (data_a[i]),
        .b       (data_b[i]),
        .y       (out_data[i])
      );
    end
  endgenerate

  mux_2_x_1 u_last_mux (
    .control (sel),
    .a       (last_a),
    .b       (last_b),
    .y       (out_last)
  );

  // A stalled beat falls through every branch, leaving state and count untouched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
          state_d = (last_q == SIDE_B) ? OWN_A : OWN_B;
        end else if (req_a) begin
          state_d = OWN_A;
        end else if (req_b) begin
          state_d = OWN_B;
        end
      end
      OWN_A, OWN_B: begin
        if (accept) begin
          if (burst_end) begin
            last_d  = own_side;
            state_d = other_req ? own_state(other_side) : IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (!own_req) begin
          last_d  = own_side;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= SIDE_B;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

endmodule
